// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirect/flush handling, decode hand-off.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branchTargetAddress,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] PCOut,
  output logic [31:0] instruction,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pending_target;

  // NOTE: every register here is state, so all assignments are non-blocking and
  // each one, including the pending target, gets an explicit asynchronous reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= RESET_PC;
      PCOut          <= RESET_PC;
      instruction    <= 32'h0;
      if_valid       <= 1'b0;
      pending_target <= 32'h0;
    end else begin
      case (state)
        // A single settling cycle after reset; any stray ack or redirect is ignored.
        IDLE: begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_addr <= RESET_PC;
        end

        FETCH: begin
          if (PCSrc) begin
            if (mem_ready) begin
              // Returning word belongs to the abandoned path; reissue at the target.
              mem_addr <= branchTargetAddress;
            end else begin
              pending_target <= branchTargetAddress;
              state          <= DROP;
            end
          end else if (mem_ready) begin
            instruction <= mem_rdata;
            PCOut       <= mem_addr;
            if_valid    <= 1'b1;
            mem_req     <= 1'b0;
            state       <= VALID;
          end
        end

        VALID: begin
          if (PCSrc) begin
            if_valid <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= branchTargetAddress;
            state    <= FETCH;
          end else if (!stall) begin
            if_valid <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= PCOut + 32'd4;
            state    <= FETCH;
          end
        end

        DROP: begin
          if (mem_ready) begin
            // A redirect arriving with the ack is newer than the pending one.
            mem_addr <= PCSrc ? branchTargetAddress : pending_target;
            state    <= FETCH;
          end else if (PCSrc) begin
            pending_target <= branchTargetAddress;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic accept;
  logic stall_hit;

  assign accept    = (state == FETCH) && mem_ready && !PCSrc;
  assign stall_hit = (state == VALID) && stall;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (accept && (fetch_count != 32'hFFFF_FFFF)) fetch_count <= fetch_count + 32'd1;
      if (stall_hit && (stall_count != 32'hFFFF_FFFF)) stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the fetch stream, checked by a scoreboard monitor.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        PCSrc;
  logic [31:0] branchTargetAddress;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] PCOut;
  logic [31:0] instruction;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .PCSrc               (PCSrc),
    .branchTargetAddress (branchTargetAddress),
    .mem_ready           (mem_ready),
    .mem_rdata           (mem_rdata),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .PCOut               (PCOut),
    .instruction         (instruction),
    .if_valid            (if_valid),
    .fetch_count         (fetch_count),
    .stall_count         (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] exp_next;
  logic        tainted;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] cnt(input logic [31:0] x);
`ifdef FETCH_PERF_CNT_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_next  = RST_PC;
    tainted   = 1'b0;
    exp_fetch = 32'h0;
    exp_stall = 32'h0;
  endtask

  // Program-order model: a redirect names the next PC to be delivered and poisons any
  // request already in flight; an untainted ack delivers the next PC in sequence.
  task automatic cyc(input logic s, input logic p, input logic [31:0] t,
                     input logic r, input logic [31:0] d);
    logic busy;
    logic shown;
    item_t it;
    busy  = mem_req;
    shown = if_valid;
    if (busy && r) begin
      if (tainted || p) begin
        if (p) exp_next = t;
      end else begin
        it.pc    = exp_next;
        it.instr = d;
        exp_q.push_back(it);
        exp_next = exp_next + 32'd4;
        if (exp_fetch != 32'hFFFF_FFFF) exp_fetch++;
      end
      tainted = 1'b0;
    end else if (busy && p) begin
      tainted  = 1'b1;
      exp_next = t;
    end else if (shown && p) begin
      exp_next = t;
    end
    if (shown && s && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    stall               = s;
    PCSrc               = p;
    branchTargetAddress = t;
    mem_ready           = r;
    mem_rdata           = d;
    @(negedge clk);
  endtask

  // Scoreboard monitor, sampling just after each rising edge.
  initial begin
    logic        pv;
    logic        pq;
    logic [31:0] pa;
    item_t       held;
    pv = 1'b0;
    pq = 1'b0;
    pa = 32'h0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pv = 1'b0;
        pq = 1'b0;
        continue;
      end
      if (if_valid && !pv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'h0, if_valid}, 32'h0);
        end else begin
          held = exp_q.pop_front();
          check("sb_pc", PCOut, held.pc);
          check("sb_instr", instruction, held.instr);
        end
      end else if (if_valid && pv) begin
        check("hold_pc", PCOut, held.pc);
        check("hold_instr", instruction, held.instr);
      end
      check("req_vs_valid", {31'h0, mem_req & if_valid}, 32'h0);
      if (pq && !mem_ready && mem_req) check("addr_stable", mem_addr, pa);
      pv = if_valid;
      pq = mem_req;
      pa = mem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_addr"}, mem_addr, RST_PC);
    check({tag, "_pc"}, PCOut, RST_PC);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
    check({tag, "_fcnt"}, fetch_count, 32'h0);
    check({tag, "_scnt"}, stall_count, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    PCSrc = 1'b0;
    branchTargetAddress = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    total = 0;
    bad = 0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("idle_req", {31'h0, mem_req}, 32'h0);

    // Sequential fetch with memory always ready: 0x0, 0x4, 0x8.
    cyc(0, 1, 32'h0000_0080, 1, 32'h0);  // redirect and ack in IDLE are ignored
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'hA000_0000);
    check("v0_valid", {31'h0, if_valid}, 32'h1);
    cyc(0, 0, 32'h0, 1, 32'h0);
    check("seq_addr4", mem_addr, 32'h4);
    cyc(0, 0, 32'h0, 1, 32'hA000_0004);
    cyc(0, 0, 32'h0, 1, 32'h0);
    check("seq_addr8", mem_addr, 32'h8);

    // Redirect while the fetch at 0x8 is unacknowledged.
    cyc(0, 1, 32'h0000_0200, 0, 32'h0);
    check("drop_addr8a", mem_addr, 32'h8);
    cyc(0, 0, 32'h0, 0, 32'h0);
    check("drop_addr8b", mem_addr, 32'h8);
    cyc(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    check("drop_novalid", {31'h0, if_valid}, 32'h0);
    check("redir_addr", mem_addr, 32'h200);
    cyc(0, 0, 32'h0, 1, 32'hB000_0200);
    check("redir_pc", PCOut, 32'h200);

    // Stall for three cycles at PC 0x10.
    cyc(0, 1, 32'h0000_0010, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'hC000_0010);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 32'h0, 1, 32'h0);
      check("stall_valid", {31'h0, if_valid}, 32'h1);
      check("stall_noreq", {31'h0, mem_req}, 32'h0);
      check("stall_pc", PCOut, 32'h10);
      check("stall_instr", instruction, 32'hC000_0010);
    end
    check("stall_cnt3", stall_count, cnt(32'd3));

    // Redirect wins over stall.
    cyc(1, 1, 32'h0000_0040, 0, 32'h0);
    check("prio_valid", {31'h0, if_valid}, 32'h0);
    check("prio_req", {31'h0, mem_req}, 32'h1);
    check("prio_addr", mem_addr, 32'h40);

    // Two redirects while dropping: the latest wins.
    cyc(0, 1, 32'h0000_0100, 0, 32'h0);
    cyc(0, 1, 32'h0000_0300, 0, 32'h0);
    check("drop2_addr", mem_addr, 32'h40);
    cyc(0, 0, 32'h0, 1, 32'h1111_1111);
    check("latest_addr", mem_addr, 32'h300);
    cyc(0, 0, 32'h0, 1, 32'hD000_0300);
    cyc(0, 0, 32'h0, 0, 32'h0);
    check("next_addr", mem_addr, 32'h304);

    // Redirect coinciding with the ack in DROP, then in FETCH.
    cyc(0, 1, 32'h0000_0500, 0, 32'h0);
    cyc(0, 1, 32'h0000_0600, 1, 32'h2222_2222);
    check("drop_same_cycle", mem_addr, 32'h600);
    cyc(0, 1, 32'h0000_0700, 1, 32'h3333_3333);
    check("fetch_redir_addr", mem_addr, 32'h700);
    check("fetch_redir_valid", {31'h0, if_valid}, 32'h0);

    // PC wrap from the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 32'h4444_4444);
    cyc(0, 0, 32'h0, 1, 32'hE000_FFFC);
    cyc(0, 0, 32'h0, 0, 32'h0);
    check("wrap_addr", mem_addr, 32'h0);
    check("fetch_cnt_dir", fetch_count, cnt(exp_fetch));
    check("stall_cnt_dir", stall_count, cnt(exp_stall));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        s;
      logic        p;
      logic        r;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      p = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 1) == 1);
      t = $urandom() & 32'hFFFF_FFFC;
      cyc(s, p, t, r, $urandom());
    end
    check("fetch_cnt_rnd", fetch_count, cnt(exp_fetch));
    check("stall_cnt_rnd", stall_count, cnt(exp_stall));

    // Reset in the middle of a request, with a late ack held across it.
    for (int i = 0; i < 20 && !mem_req; i++) cyc(0, 0, 32'h0, 0, 32'h0);
    check("reach_fetch", {31'h0, mem_req}, 32'h1);
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_5555;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("post_idle_req", {31'h0, mem_req}, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h6666_6666);
    check("restart_req", {31'h0, mem_req}, 32'h1);
    check("restart_addr", mem_addr, RST_PC);
    check("restart_novalid", {31'h0, if_valid}, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'hF000_0000);
    check("restart_pc", PCOut, RST_PC);
    cyc(0, 0, 32'h0, 0, 32'h0);
    check("restart_next", mem_addr, RST_PC + 32'd4);

    repeat (4) cyc(0, 0, 32'h0, 0, 32'h0);
    check("queue_empty", exp_q.size(), 32'h0);
    check("fetch_cnt_end", fetch_count, cnt(exp_fetch));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
